// File: rtl/data_mem_pkg.sv
// Shared types and command encodings for the data-memory load/store sequencer.
// Optional timeout support is enabled with DMEM_TIMEOUT_EN.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic DMEM_CMD_LOAD  = 1'b0;
    localparam logic DMEM_CMD_STORE = 1'b1;

endpackage

// File: rtl/dmem_watchdog.sv
// REQ-cycle timeout counter for the data-memory sequencer.
// Instantiated only when DMEM_TIMEOUT_EN is defined.
module dmem_watchdog
    import data_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (count) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Fires on the un-acked REQ cycle that would make the count reach the limit.
    assign expired = count && (cnt == LAST);

endmodule

// File: rtl/data_mem_access.sv
// Load/store sequencer between the register file and synchronous data RAM.
// Define DMEM_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES un-acked cycles.
module data_mem_access
    import data_mem_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int D_ADDR_WIDTH   = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [D_ADDR_WIDTH-1:0] dmar,
    input  logic [DATA_W-1:0]       acc_out,
    output logic [DATA_W-1:0]       acc_in,
    output logic                    acc_write_enable,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [D_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ack
);

    dmem_state_t             state;
    logic                    cmd_q;
    logic [D_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    accept;
    logic                    waiting;
    logic                    expired;

    assign accept  = (state == IDLE) && start;
    assign waiting = (state == REQ) && !mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cmd_q   <= DMEM_CMD_LOAD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= REQ;
                        addr_q  <= dmar;
                        wdata_q <= acc_out;
                        cmd_q   <= is_store;
                    end
                end
                REQ: begin
                    // An ack on the expiry cycle still completes normally.
                    if (mem_ack) begin
                        state <= DONE;
                        if (cmd_q == DMEM_CMD_LOAD) begin
                            rdata_q <= mem_rdata;
                        end
                    end else if (expired) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    logic error_q;

    dmem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (accept),
        .count  (waiting),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (waiting && expired) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign expired = 1'b0;
    assign error   = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) && (cmd_q == DMEM_CMD_STORE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign acc_in    = rdata_q;

    // A timed-out load has no valid data, so it must not touch the accumulator.
    assign acc_write_enable = (state == DONE)
                           && (cmd_q == DMEM_CMD_LOAD)
                           && !error;

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: directed scenarios plus random
// traffic compared each cycle against a transaction-level reference model.
module tb_data_mem_access;

    localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_store;
    logic [11:0] dmar;
    logic [7:0]  acc_out;
    logic [7:0]  acc_in;
    logic        acc_write_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int failures = 0;

    // Environment memory (written from DUT outputs) and the model's own copy.
    logic [7:0] mem [4096];
    logic [7:0] ref_mem [4096];

    // Reference model: transaction-level view of the sequencer.
    int         m_phase = 0;
    int         m_waits = 0;
    logic       t_store = 1'b0;
    logic [11:0] t_addr = '0;
    logic [7:0] t_data = '0;
    logic [7:0] m_acc = '0;
    logic       m_err = 1'b0;
    bit         cmp_on = 1'b0;

    data_mem_access #(
        .DATA_W        (8),
        .D_ADDR_WIDTH  (12),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .is_store        (is_store),
        .dmar            (dmar),
        .acc_out         (acc_out),
        .acc_in          (acc_in),
        .acc_write_enable(acc_write_enable),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_waits = 0;
            t_store = 1'b0;
            t_addr  = '0;
            t_data  = '0;
            m_acc   = '0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    t_addr  = dmar;
                    t_data  = acc_out;
                    t_store = is_store;
                    m_err   = 1'b0;
                    m_waits = 0;
                    m_phase = 1;
                end
                1: if (mem_ack) begin
                    if (t_store) ref_mem[t_addr] = t_data;
                    else m_acc = ref_mem[t_addr];
                    m_phase = 2;
                end else begin
                    m_waits++;
                    if (TO_EN && m_waits == TO) begin
                        m_err   = 1'b1;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
            chk("mem_we", 32'(mem_we), 32'(m_phase == 1 && t_store));
            chk("mem_addr", 32'(mem_addr), 32'(t_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(t_data));
            chk("acc_in", 32'(acc_in), 32'(m_acc));
            chk("acc_we", 32'(acc_write_enable),
                32'(m_phase == 2 && !t_store && !m_err));
            chk("error", 32'(error), 32'(m_err));
        end
    end

    task automatic tick(input logic s, input logic st, input logic [11:0] a,
                        input logic [7:0] d, input logic ack);
        logic        wr;
        logic [11:0] wa;
        logic [7:0]  wd;
        start     = s;
        is_store  = st;
        dmar      = a;
        acc_out   = d;
        mem_ack   = ack;
        mem_rdata = ack ? mem[mem_addr] : 8'($urandom);
        wr = ack && mem_req && mem_we;
        wa = mem_addr;
        wd = mem_wdata;
        @(posedge clk);
        #1;
        if (wr) mem[wa] = wd;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ndone;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset_n = 1'b0;
        start = 1'b0; is_store = 1'b0; dmar = '0; acc_out = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        cmp_on = 1'b1;
        idle(); idle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_acc_in", 32'(acc_in), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        idle();

        // Zero-wait load.
        mem[12'h3A5] = 8'h7E; ref_mem[12'h3A5] = 8'h7E;
        tick(1'b1, 1'b0, 12'h3A5, 8'h11, 1'b0);
        chk("ld_req", 32'(mem_req), 32'd1);
        chk("ld_addr", 32'(mem_addr), 32'h3A5);
        chk("ld_we", 32'(mem_we), 32'd0);
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        chk("ld_done", 32'(done), 32'd1);
        chk("ld_acc_we", 32'(acc_write_enable), 32'd1);
        chk("ld_acc_in", 32'(acc_in), 32'h7E);
        idle();
        chk("ld_idle", 32'(busy), 32'd0);

        // Store with 3 wait cycles, acc_out changing after start.
        tick(1'b1, 1'b1, 12'h012, 8'hC3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("st_wdata", 32'(mem_wdata), 32'hC3);
            chk("st_we", 32'(mem_we), 32'd1);
            tick(1'b0, 1'b0, 12'hFFF, 8'h00, k == 3);
        end
        chk("st_done", 32'(done), 32'd1);
        chk("st_no_acc_we", 32'(acc_write_enable), 32'd0);
        idle();
        chk("st_mem", 32'(mem[12'h012]), 32'hC3);

        // start held high through a 2-wait load.
        ndone = 0;
        tick(1'b1, 1'b0, 12'h020, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 12'h0A0 + 12'(k), 8'h00, k == 2);
            if (done) ndone++;
        end
        tick(1'b1, 1'b0, 12'h0B0, 8'h00, 1'b0);
        if (done) ndone++;
        chk("hold_idle_gap", 32'(busy), 32'd0);
        chk("hold_one_done", 32'(ndone), 32'd1);
        tick(1'b1, 1'b0, 12'h0C0, 8'h00, 1'b0);
        chk("hold_second", 32'(mem_addr), 32'h0C0);
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        idle();

        // Asynchronous reset during REQ.
        tick(1'b1, 1'b0, 12'h0AB, 8'h00, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
            chk("arst_no_acc_we", 32'(acc_write_enable), 32'd0);
        end

`ifdef DMEM_TIMEOUT_EN
        tick(1'b1, 1'b0, 12'h055, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        chk("to_req_4th", 32'(mem_req), 32'd1);
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_done", 32'(done), 32'd1);
        chk("to_error", 32'(error), 32'd1);
        chk("to_no_acc_we", 32'(acc_write_enable), 32'd0);
        idle();
        chk("to_sticky", 32'(error), 32'd1);
        tick(1'b1, 1'b0, 12'h055, 8'h00, 1'b0);
        chk("to_clear", 32'(error), 32'd0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        chk("to_ack_win", 32'(error), 32'd0);
        chk("to_ack_acc_we", 32'(acc_write_enable), 32'd1);
        idle();
`endif

        // Store 0x55 to 0x100, then load it back.
        tick(1'b1, 1'b1, 12'h100, 8'h55, 1'b0);
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        idle();
        tick(1'b1, 1'b0, 12'h100, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
        chk("rt_acc_we", 32'(acc_write_enable), 32'd1);
        idle();
        chk("rt_acc_in", 32'(acc_in), 32'h55);

        // Random traffic over a small address window.
        for (int i = 0; i < 2000; i++) begin
            logic s, st, ack;
            s   = ($urandom % 3) == 0;
            st  = 1'($urandom);
            ack = mem_req ? (($urandom % 3) == 0) : 1'($urandom);
            tick(s, st, {8'h00, 4'($urandom)}, 8'($urandom), ack);
        end
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
